// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Sequencer between the MEM-stage pipeline logic and a byte-wide data memory.
// One byte, halfword or word load/store is accepted per transaction. It is
// split into single-byte memory accesses in little-endian order: byte k goes
// to address base + k, with the 32-bit add wrapping. Loads are assembled and
// then sign- or zero-extended. The pipeline is held off (req_ready_o low)
// until the response pulse has been delivered.
//
// Handshake: a request transfers on a rising edge where req_valid_i and
// req_ready_o are both high. All req_* fields are latched at that edge.
// req_ready_o is high only while idle, and req_valid_i is ignored otherwise.
// rsp_valid_o is a one-cycle completion pulse that carries no back-pressure.
//
// Parameters:
//   RD_LATENCY     cycles from a read issue cycle to the cycle in which
//                  mem_data_i[7:0] is valid (1..3)
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   req_valid_i    request present
//   req_ready_o    unit can accept a request (idle)
//   req_we_i       1 = store, 0 = load
//   req_size_i     00 byte, 01 half, 10/11 word
//   req_unsigned_i loads: 1 zero-extend, 0 sign-extend
//   req_addr_i     byte address of lowest byte
//   req_wdata_i    store data, byte k in [8k+7:8k]
//   rsp_valid_o    one-cycle completion pulse
//   rsp_rdata_o    load result (0 for stores), held until next completion
//   mem_addr_o     byte address to data memory (held outside issue cycles)
//   mem_data_o     write byte in [7:0], upper bits 0
//   mem_signal_o   bit0 write, bit1 read, bit2 always 0
//   mem_data_i     read byte in [7:0]
//   dbg_state_o    current sequencer state (IDLE=0, ISSUE=1, WAIT=2, DONE=3)
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int RD_LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic [2:0]  mem_signal_o,
    input  logic [31:0] mem_data_i,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Value of the wait counter on the cycle in which read data is valid.
    localparam logic [1:0] WAIT_LAST = 2'(RD_LATENCY - 1);

    state_t      state_q, state_d;
    logic [1:0]  k_q;          // byte index within the transaction
    logic [1:0]  wcnt_q;       // cycles spent in the current WAIT
    logic        we_q;
    logic        uns_q;
    logic [1:0]  size_q;
    logic [31:0] base_q;
    logic [31:0] wdata_q;
    logic [31:0] asm_q;        // load bytes gathered so far
    logic [31:0] rdata_q;      // response data, changes only entering DONE
    logic [31:0] last_addr_q;  // last address driven during an issue cycle

    logic [1:0]  last_k;
    logic        byte_last;
    logic        wait_last;
    logic [31:0] issue_addr;
    logic [7:0]  wbyte;
    logic [31:0] asm_next;
    logic [31:0] load_result;
    logic        unused_mem_bits;

    assign unused_mem_bits = ^mem_data_i[31:8];

    always_comb begin
        last_k = 2'd3;
        case (size_q)
            2'b00:   last_k = 2'd0;
            2'b01:   last_k = 2'd1;
            default: last_k = 2'd3;
        endcase
    end

    assign byte_last  = (k_q == last_k);
    assign wait_last  = (wcnt_q == WAIT_LAST);
    assign issue_addr = base_q + {30'd0, k_q};
    assign wbyte      = wdata_q[{k_q, 3'b000} +: 8];

    // Incoming byte merged into the assembly register at position k.
    always_comb begin
        asm_next = asm_q;
        asm_next[{k_q, 3'b000} +: 8] = mem_data_i[7:0];
    end

    always_comb begin
        load_result = asm_next;
        case (size_q)
            2'b00:   load_result = uns_q ? {24'd0, asm_next[7:0]}
                                         : {{24{asm_next[7]}}, asm_next[7:0]};
            2'b01:   load_result = uns_q ? {16'd0, asm_next[15:0]}
                                         : {{16{asm_next[15]}}, asm_next[15:0]};
            default: load_result = asm_next;
        endcase
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and outputs
    always_comb begin
        state_d      = state_q;
        req_ready_o  = 1'b0;
        rsp_valid_o  = 1'b0;
        mem_addr_o   = last_addr_q;
        mem_data_o   = 32'd0;
        mem_signal_o = 3'b000;
        case (state_q)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_addr_o = issue_addr;
                if (we_q) begin
                    mem_signal_o = 3'b001;
                    mem_data_o   = {24'd0, wbyte};
                    state_d      = byte_last ? S_DONE : S_ISSUE;
                end else begin
                    mem_signal_o = 3'b010;
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_last) begin
                    state_d = byte_last ? S_DONE : S_ISSUE;
                end
            end
            S_DONE: begin
                rsp_valid_o = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            k_q         <= 2'd0;
            wcnt_q      <= 2'd0;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            size_q      <= 2'b00;
            base_q      <= 32'd0;
            wdata_q     <= 32'd0;
            asm_q       <= 32'd0;
            rdata_q     <= 32'd0;
            last_addr_q <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        we_q    <= req_we_i;
                        uns_q   <= req_unsigned_i;
                        size_q  <= req_size_i;
                        base_q  <= req_addr_i;
                        wdata_q <= req_wdata_i;
                        k_q     <= 2'd0;
                        wcnt_q  <= 2'd0;
                        asm_q   <= 32'd0;
                    end
                end
                S_ISSUE: begin
                    last_addr_q <= issue_addr;
                    wcnt_q      <= 2'd0;
                    if (we_q) begin
                        k_q <= k_q + 2'd1;
                        if (byte_last) begin
                            rdata_q <= 32'd0;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_last) begin
                        asm_q <= asm_next;
                        k_q   <= k_q + 2'd1;
                        if (byte_last) begin
                            rdata_q <= load_result;
                        end
                    end else begin
                        wcnt_q <= wcnt_q + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_rdata_o = rdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequencer between the CPU's MEM-stage pipeline logic and the byte-wide data memory. Accepts one byte/halfword/word load or store request per transaction. Splits it into single-byte memory accesses in little-endian order, and for loads assembles and sign/zero-extends the result. Holds the pipeline off (ready low) until the response is delivered.

## Interface
Parameters:
- RD_LATENCY, 1, cycles from a read issue cycle to the cycle in which mem_data_i[7:0] is valid; legal range 1..3.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset; one clock, synchronous, active-high.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  unit can accept a request.
- req_we_i  in  1  1 = store, 0 = load.
- req_size_i  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
- req_unsigned_i  in  1  loads: 1 zero-extend, 0 sign-extend; ignored for word and stores.
- req_addr_i  in  32  byte address of lowest byte.
- req_wdata_i  in  32  store data; byte k = bits [8k+7:8k].
- rsp_valid_o  out  1  one-cycle pulse: transaction complete.
- rsp_rdata_o  out  32  load result; valid while rsp_valid_o = 1; 0 for stores.
- mem_addr_o  out  32  byte address to data memory.
- mem_data_o  out  32  write byte in [7:0], [31:8] = 0.
- mem_signal_o  out  3  bit0 write, bit1 read, bit2 always 0; at most one of bit0/bit1 set.
- mem_data_i  in  32  read byte from data memory in [7:0]; [31:8] ignored.

## Operation
- N = 1, 2 or 4 bytes from req_size_i. Byte k goes to address req_addr_i + k (32-bit add, wraps at 2^32). No alignment requirement.
- Handshake: transfer when req_valid_i & req_ready_o at a rising edge. All req_* fields latched then; later changes ignored. req_ready_o = 1 only in IDLE.
- States:
  - IDLE: accept request -> ISSUE, byte index k = 0.
  - ISSUE: drive mem_addr_o = base + k.
    - Store: mem_signal_o = 001, mem_data_o = {24'd0, wdata byte k}. Then k++; go to DONE if k was N-1, else stay in ISSUE.
    - Load: mem_signal_o = 010 -> WAIT.
  - WAIT, load only: lasts RD_LATENCY cycles with mem_signal_o = 000. On its last cycle, mem_data_i[7:0] is captured into assembly byte k. Then k++ and go to ISSUE, or to DONE after byte N-1.
  - DONE: rsp_valid_o = 1 for exactly one cycle -> IDLE.
- Load result:
  - Byte k lands in bits [8k+7:8k].
  - Byte/half: upper bits = 0 if req_unsigned_i, else replicated bit 7 (byte) or bit 15 (half).
- Outputs outside ISSUE: mem_signal_o = 000; mem_addr_o holds its last value; mem_data_o = 0.
- rsp_rdata_o holds its value after DONE until the next DONE.

## Timing
- Reset values: req_ready_o = 1, rsp_valid_o = 0, rsp_rdata_o = 0, mem_addr_o = 0, mem_data_o = 0, mem_signal_o = 000, state IDLE.
- Store latency: acceptance edge, then N write cycles, then 1 DONE cycle. req_ready_o is high again at cycle N+2.
- Load latency: N×(1+RD_LATENCY) cycles, then 1 DONE cycle. With RD_LATENCY = 1, a word load takes 8 access cycles plus DONE.
- No back-to-back acceptance: minimum one IDLE cycle between transactions.
- Reset mid-transaction: next edge forces all reset values. No rsp_valid_o pulse for the aborted request. Bytes already written stay written.
- rst_i overrides a simultaneous request; nothing is accepted on a reset edge.
- req_valid_i is ignored whenever req_ready_o = 0.

## Test plan
- Store word 0xA1B2C3D4 @0x10: mem_signal_o = 001 on 4 consecutive cycles with (addr, data[7:0]) = (0x10, D4), (0x11, C3), (0x12, B2), (0x13, A1). rsp_valid_o on cycle 5, rsp_rdata_o = 0, ready on cycle 6.
- Then load word @0x10, RD_LATENCY = 1: read issues at 0x10..0x13 on alternate cycles. rsp_valid_o on cycle 9 with rsp_rdata_o = 0xA1B2C3D4.
- Load byte @0x13: signed -> 0xFFFFFFA1; unsigned -> 0x000000A1. Load half @0x10 signed -> 0xFFFFC3D4.
- Misaligned/wrap: store half 0xBEEF @0xFFFFFFFF -> EF written @0xFFFFFFFF, BE @0x00000000. Signed half load at the same address -> 0xFFFFBEEF.
- Reset mid-load: assert rst_i for one cycle during the second WAIT of a word load. Next cycle: req_ready_o = 1, mem_signal_o = 000, rsp_rdata_o = 0, and no rsp_valid_o pulse ever.
- Handshake hold-off: keep req_valid_i high with changing req_addr_i during a busy store. Only the first request executes, and a second transaction is accepted only after the DONE cycle.
